// File: rtl/ccip_async_multi_active_cnt.sv
// Per-channel pending-line counters with saturation, sticky error flags,
// high-water marks, almost-full warnings and a drain/quiesce handshake.
module ccip_async_multi_active_cnt #(
  parameter int N_CHAN        = 2,
  parameter int CNT_W         = 10,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CHAN-1:0]         req_valid,
  input  logic [2*N_CHAN-1:0]       req_len,
  input  logic [N_CHAN-1:0]         rsp_valid,
  input  logic [2*N_CHAN-1:0]       rsp_len,
  input  logic                      drain_req,
  input  logic                      peak_clr,
  output logic [N_CHAN*CNT_W-1:0]   cnt,
  output logic [N_CHAN*CNT_W-1:0]   peak,
  output logic [N_CHAN-1:0]         almost_full,
  output logic [N_CHAN-1:0]         err_ovf,
  output logic [N_CHAN-1:0]         err_udf,
  output logic                      req_block,
  output logic                      idle,
  output logic                      drain_done
);

  localparam int SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] AF_TH   = CNT_W'((2**CNT_W) - ALMFULL_SLACK);

  logic [N_CHAN-1:0] next_zero;

  generate
    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
      logic [2:0]          incr;
      logic [2:0]          decr;
      logic signed [SW-1:0] sum;
      logic [CNT_W-1:0]    cnt_reg;
      logic [CNT_W-1:0]    cnt_next;
      logic [CNT_W-1:0]    peak_reg;
      logic                af_reg;
      logic                ovf_reg;
      logic                udf_reg;
      logic                ovf_next;
      logic                udf_next;

      // Two spare bits let both overflow and a negative result be seen before clamping.
      always_comb begin
        incr     = req_valid[gi] ? ({1'b0, req_len[2*gi +: 2]} + 3'd1) : 3'd0;
        decr     = rsp_valid[gi] ? ({1'b0, rsp_len[2*gi +: 2]} + 3'd1) : 3'd0;
        sum      = $signed({2'b00, cnt_reg})
                 + $signed({{(SW-3){1'b0}}, incr})
                 - $signed({{(SW-3){1'b0}}, decr});
        cnt_next = sum[CNT_W-1:0];
        ovf_next = 1'b0;
        udf_next = 1'b0;
        if (sum[SW-1]) begin
          cnt_next = '0;
          udf_next = 1'b1;
        end else if (sum > $signed({2'b00, CNT_MAX})) begin
          cnt_next = CNT_MAX;
          ovf_next = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg  <= '0;
          peak_reg <= '0;
          af_reg   <= 1'b0;
          ovf_reg  <= 1'b0;
          udf_reg  <= 1'b0;
        end else begin
          cnt_reg <= cnt_next;
          af_reg  <= (cnt_next >= AF_TH);
          ovf_reg <= ovf_reg | ovf_next;
          udf_reg <= udf_reg | udf_next;
          if (peak_clr || (cnt_next > peak_reg)) peak_reg <= cnt_next;
        end
      end

      assign cnt[gi*CNT_W +: CNT_W]  = cnt_reg;
      assign peak[gi*CNT_W +: CNT_W] = peak_reg;
      assign almost_full[gi]         = af_reg;
      assign err_ovf[gi]             = ovf_reg;
      assign err_udf[gi]             = udf_reg;
      assign next_zero[gi]           = (cnt_next == '0);
    end
  endgenerate

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state_reg, state_next;
  logic   idle_reg;

  // Withdrawing drain_req always wins, so DONE is only reachable while still requested.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:   if (drain_req) state_next = DRAIN;
      DRAIN: begin
        if (!drain_req) state_next = RUN;
        else if (idle_reg && !(|req_valid) && !(|rsp_valid)) state_next = DONE;
      end
      DONE: begin
        if (!drain_req) state_next = RUN;
        else if (|req_valid) state_next = DRAIN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      idle_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      idle_reg  <= &next_zero;
    end
  end

  assign idle       = idle_reg;
  assign req_block  = (state_reg != RUN);
  assign drain_done = (state_reg == DONE);

endmodule

// File: doc/ccip_async_multi_active_cnt.md
CCIP_ASYNC_MULTI_ACTIVE_CNT -- requirements
Module: ccip_async_multi_active_cnt

Interface
REQ-001 SHALL have parameter N_CHAN, default 2, number of independently tracked channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 10, width of each per-channel pending-line counter.
REQ-003 SHALL have parameter ALMFULL_SLACK, default 8, headroom below counter maximum at which almost_full asserts; legal range 4..(2**CNT_W)-1.
REQ-004 SHALL have port clk, input, 1, clock; reset reset, synchronous, active-high; clock clk.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, N_CHAN, per-channel request issued this cycle.
REQ-007 SHALL have port req_len, input, 2*N_CHAN, per-channel request line count minus one (0..3 = 1..4 lines).
REQ-008 SHALL have port rsp_valid, input, N_CHAN, per-channel response received this cycle.
REQ-009 SHALL have port rsp_len, input, 2*N_CHAN, per-channel lines retired by the response minus one (packed write responses).
REQ-010 SHALL have port drain_req, input, 1, level request to quiesce all channels.
REQ-011 SHALL have port peak_clr, input, 1, one-cycle pulse clearing all high-water marks.
REQ-012 SHALL have port cnt, output, N_CHAN*CNT_W, per-channel pending-line count.
REQ-013 SHALL have port peak, output, N_CHAN*CNT_W, per-channel high-water mark of cnt.
REQ-014 SHALL have port almost_full, output, N_CHAN, per-channel credit-exhaustion warning.
REQ-015 SHALL have port err_ovf / err_udf, output, N_CHAN each, sticky per-channel overflow / underflow flags.
REQ-016 SHALL have ports req_block, idle, drain_done, output, 1 each: stop-issuing request, all counts zero, drain complete.

Function
REQ-017 Per channel, incr SHALL be req_valid ? req_len+1 : 0; decr SHALL be rsp_valid ? rsp_len+1 : 0; both 3 bits.
REQ-018 cnt SHALL update one cycle after inputs: cnt <= cnt + incr - decr, computed at CNT_W+2 bits signed.
REQ-019 Simultaneous request and response on one channel SHALL net in the same cycle (e.g. cnt 5, incr 2, decr 1 -> 6).
REQ-020 If the signed result exceeds 2**CNT_W-1, cnt SHALL saturate at 2**CNT_W-1 and err_ovf for that channel SHALL set.
REQ-021 If the signed result is negative, cnt SHALL clamp to 0 and err_udf for that channel SHALL set.
REQ-022 err_ovf/err_udf SHALL remain set until reset; no wrap-around is ever permitted.
REQ-023 almost_full SHALL be registered from next cnt, asserted when next cnt >= 2**CNT_W - ALMFULL_SLACK, so it is coincident with cnt.
REQ-024 peak SHALL update to next cnt when next cnt > peak, same cycle as cnt; peak_clr SHALL load peak with next cnt (clear wins over compare).
REQ-025 idle SHALL be registered, 1 when every next cnt equals 0.
REQ-026 Channels SHALL be fully independent; activity on one SHALL not alter another's cnt, peak, flags or almost_full.
REQ-027 Drain FSM states: RUN, DRAIN, DONE; req_block = (state != RUN); drain_done = (state == DONE).
REQ-028 RUN -> DRAIN when drain_req=1.
REQ-029 DRAIN -> DONE when idle=1 and no req_valid/rsp_valid this cycle; DRAIN -> RUN when drain_req=0.
REQ-030 DONE -> RUN when drain_req=0; DONE -> DRAIN when any req_valid=1 while drain_req=1.
REQ-031 Requests presented while req_block=1 SHALL still be counted (never dropped).
REQ-032 Minimum drain latency with all counts zero: drain_req at cycle 0 -> req_block at cycle 1 -> drain_done at cycle 2.

Reset
REQ-033 On reset: cnt=0, peak=0, almost_full=0, err_ovf=0, err_udf=0, idle=1, state=RUN, req_block=0, drain_done=0.
REQ-034 Reset asserted mid-operation SHALL override all inputs in that cycle, including peak_clr and drain_req.
REQ-035 First input sampled after reset release SHALL be counted normally.

Verification
REQ-036 Ch0 req_len=3 x3 cycles, then rsp_len=0 x12 -> cnt0 12 then 0, peak0=12, idle returns 1, ch1 untouched.
REQ-037 CNT_W=4, SLACK=4: ch0 drives cnt to 12 -> almost_full=1; next incr 4 -> cnt 15, err_ovf0=1.
REQ-038 cnt1=1, rsp_len=1 -> cnt1=0, err_udf1=1, sticky through later traffic until reset.
REQ-039 cnt0=5, same-cycle req_len=1 and rsp_len=0 -> cnt0=6; peak_clr same cycle -> peak0=6.
REQ-040 cnt0=3, drain_req=1 -> req_block next cycle; retire 3 lines -> drain_done; late req in DONE -> DRAIN; drain_req=0 -> RUN.
REQ-041 Reset asserted with cnt nonzero, errors set and state DONE -> all outputs at REQ-033 values next cycle.
